// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus between if_fetch (master) and imem (slave).
// One request outstanding at a time; addr is a byte address of a 32-bit word.
interface if_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input ready, rvalid, rdata);
  modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: owns the fetch PC, issues single-outstanding fetches and queues returned words.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_stall,
  input  logic              branch_flag,
  input  logic [31:0]       branch_target_address,
  if_fetch_if.master        mem,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_inst,
  output logic              stallreq_if
`ifdef FETCH_MISALIGN_EN
  ,
  output logic              if_misalign
`endif
);

  localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   issued_addr;
  logic [31:0]   redirect_pc;
  logic          req_q, req_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   pc_q   [QDEPTH];
  logic [31:0]   inst_q [QDEPTH];
  logic          accept, push, pop;
  logic          misalign_q, misalign_nxt;

`ifdef FETCH_MISALIGN_EN
  assign redirect_pc  = branch_target_address;
  assign misalign_nxt = branch_flag ? (|branch_target_address[1:0]) : misalign_q;
  assign if_misalign  = misalign_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_q <= 1'b0;
    else      misalign_q <= misalign_nxt;
  end
`else
  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^branch_target_address[1:0];
  assign redirect_pc     = {branch_target_address[31:2], 2'b00};
  assign misalign_q      = 1'b0;
  assign misalign_nxt    = 1'b0;
`endif

  // A redirect cancels any same-cycle push/pop; the queue is flushed instead.
  assign accept = mem.req & mem.ready;
  assign push   = (state == WAIT) & mem.rvalid & ~branch_flag;
  assign pop    = (count != '0) & ~if_stall & ~branch_flag;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    count_nxt    = count;
    if (branch_flag) begin
      fetch_pc_nxt = redirect_pc;
      count_nxt    = '0;
      // A request accepted in the redirect cycle still returns a stale word to drop.
      case (state)
        IDLE:    state_nxt = accept ? DROP : IDLE;
        default: state_nxt = mem.rvalid ? IDLE : DROP;
      endcase
    end else begin
      count_nxt = count + CW'(push) - CW'(pop);
      case (state)
        IDLE: begin
          if (accept) begin
            state_nxt    = WAIT;
            fetch_pc_nxt = fetch_pc + 32'd4;
          end
        end
        WAIT, DROP: begin
          if (mem.rvalid) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
    // Only request while a queue slot is free for the in-flight word.
    req_nxt = (state_nxt == IDLE) & (count_nxt < CW'(QDEPTH)) & ~misalign_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      issued_addr <= RESET_PC;
      req_q       <= 1'b0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_q    <= req_nxt;
      count    <= count_nxt;
      if (accept) issued_addr <= fetch_pc;
      if (branch_flag) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Queue payload storage; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]   <= issued_addr;
      inst_q[wr_ptr] <= mem.rdata;
    end
  end

  assign mem.req     = req_q;
  assign mem.addr    = fetch_pc;
  assign stallreq_if = (count == '0) | misalign_q;
  assign if_pc       = (count == '0) ? fetch_pc : pc_q[rd_ptr];
  assign if_inst     = (count == '0) ? NOP_INST : inst_q[rd_ptr];

  // Memory must never answer while nothing is outstanding.
  assert property (@(posedge clk) disable iff (!rst) !((state == IDLE) && mem.rvalid));

endmodule
